cmp_checker: RTL and testbench
==============================

CMP_CHECKER -- requirements
Module: cmp_checker

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 4, operand width.
- SIGNED, default 0; 1 selects two's-complement comparison.
- N_SAMPLES, default 2**(2*WIDTH), beats per run.
- CNT_W, default 16, counter width.

REQ-002 Ports SHALL be as follows; clock is single, reset is synchronous active-high:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a run.
- in_valid  in  1  sample beat present.
- a  in  WIDTH  operand A applied to the DUT comparator.
- b  in  WIDTH  operand B applied to the DUT comparator.
- equal  in  1  DUT flag.
- greater  in  1  DUT flag.
- lower  in  1  DUT flag.
- in_ready  out  1  beat accepted this cycle.
- busy  out  1  run in progress.
- done  out  1  run complete (level).
- chk_cnt  out  CNT_W  beats checked.
- err_cnt  out  CNT_W  beats failing.
- fail_flag  out  1  at least one failure captured.
- fail_a  out  WIDTH  operand A of the first failing beat.
- fail_b  out  WIDTH  operand B of the first failing beat.
- fail_code  out  3  {equal,greater,lower} of the first failing beat.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE.
REQ-004 Transitions SHALL be:
- IDLE->RUN on start.
- RUN->DONE on the cycle the N_SAMPLES-th beat is accepted.
- DONE->RUN on start.
- start in RUN is ignored.
REQ-005 Entering RUN SHALL clear chk_cnt, err_cnt, fail_flag, fail_a, fail_b and fail_code in the same cycle start is sampled.
REQ-006 in_ready SHALL be 1 exactly when the state is RUN; a beat is accepted when in_valid and in_ready are both 1.
REQ-007 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-008 Expected flags SHALL be computed as follows:
- exp_eq = (a==b).
- exp_gt = (a>b) and exp_lt = (a<b), compared signed when SIGNED=1 and unsigned otherwise.
REQ-009 A beat SHALL fail if {equal,greater,lower} differs from {exp_eq,exp_gt,exp_lt}, which covers non-one-hot and all-zero flag sets.
REQ-010 Every accepted beat SHALL increment chk_cnt by 1; every failing accepted beat SHALL increment err_cnt by 1.
REQ-011 Both counters SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-012 Counter updates SHALL be visible one clock after acceptance.
REQ-013 On the first failing beat of a run, fail_a, fail_b and fail_code SHALL be captured and fail_flag set one clock later; later failures SHALL NOT overwrite them.
REQ-014 Beats presented while not in RUN SHALL be ignored with no counter or capture change.
REQ-015 A failing final beat SHALL be counted and captured in the same cycle the FSM enters DONE.
REQ-016 All outputs SHALL be registered except in_ready, busy and done, which decode the state register.

Reset
REQ-017 When rst=1 at a clk edge, the next state SHALL be IDLE and all counters and fail fields SHALL be 0.
REQ-018 rst SHALL override start and in_valid in the same cycle.
REQ-019 Reset mid-RUN SHALL abandon the run; a later start SHALL begin a fresh run.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then start; sweep all 256 (a,b) pairs, WIDTH=4, SIGNED=0, with a correct model -> done=1, chk_cnt=256, err_cnt=0, fail_flag=0.
- SIGNED=1, a=4'hF, b=4'h1, flags {0,0,1} -> no error.
- Same operands with SIGNED=0 -> err_cnt=1, fail_code=3'b001.
- Inject flags {1,1,0} at beat 10 (a=0,b=10) and {0,0,0} at beat 20 -> err_cnt=2, fail_a=0, fail_b=10, fail_code=3'b110.
- Toggle in_valid every other cycle during RUN -> only valid beats counted; done exactly on the 256th accepted beat.
- Assert rst after 100 beats -> all outputs 0 in IDLE; a new start plus 256 beats -> chk_cnt=256.
- start asserted in RUN -> counters not cleared.
- start in DONE -> new run with counters cleared.

Source files
------------

// File: rtl/cmp_checker.sv
// cmp_checker: checks the equal/greater/lower flags of an external comparator
// against a locally computed reference over a run of N_SAMPLES accepted beats.
// It keeps saturating beat and failure counters and captures the operands and
// flags of the first failing beat of each run.
//
// Handshake: in_ready is high exactly while a run is in progress. A beat is
// accepted on every clock edge where in_valid and in_ready are both high; the
// source may hold in_valid high across consecutive cycles to stream beats
// back to back. Beats offered while in_ready is low are dropped without effect.
module cmp_checker #(
    parameter int WIDTH     = 4,
    parameter int SIGNED    = 0,
    parameter int N_SAMPLES = 2**(2*WIDTH),
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             equal,
    input  logic             greater,
    input  logic             lower,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_flag,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_code
);

    // Beat counter must reach N_SAMPLES regardless of how narrow CNT_W is,
    // so it has its own width instead of reusing chk_cnt.
    localparam int BEAT_W = $clog2(N_SAMPLES + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BEAT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic [CNT_W-1:0]  chk_cnt_q,   chk_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;
    logic              fail_flag_q, fail_flag_d;
    logic [WIDTH-1:0]  fail_a_q,    fail_a_d;
    logic [WIDTH-1:0]  fail_b_q,    fail_b_d;
    logic [2:0]        fail_code_q, fail_code_d;

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic [2:0]            exp_flags;
    logic [2:0]            dut_flags;
    logic                  beat_fail;
    logic                  accept;
    logic                  run_start;
    logic                  last_beat;

    // Reference comparison: one extra bit lets a single signed compare serve
    // both modes (sign-extend for two's complement, zero-extend otherwise).
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        if (SIGNED != 0) begin
            a_ext = {a[WIDTH-1], a};
            b_ext = {b[WIDTH-1], b};
        end else begin
            a_ext = {1'b0, a};
            b_ext = {1'b0, b};
        end
        exp_flags = {(a_ext == b_ext), (a_ext > b_ext), (a_ext < b_ext)};
        dut_flags = {equal, greater, lower};
        // Any difference fails, including non-one-hot and all-zero flag sets.
        beat_fail = (dut_flags != exp_flags);
    end

    // Handshake and run-control decodes from the state register.
    always_comb begin
        in_ready  = (state_q == RUN);
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        accept    = in_valid && (state_q == RUN);
        // start is only honoured outside RUN; a pulse mid-run is ignored.
        run_start = start && (state_q != RUN);
        last_beat = (beat_cnt_q == LAST_BEAT);
    end

    // Next-state logic: IDLE/DONE wait for start, RUN ends on the final beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter and first-failure capture updates; a new run wipes everything.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        err_cnt_d   = err_cnt_q;
        fail_flag_d = fail_flag_q;
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_code_d = fail_code_q;
        if (run_start) begin
            beat_cnt_d  = '0;
            chk_cnt_d   = '0;
            err_cnt_d   = '0;
            fail_flag_d = 1'b0;
            fail_a_d    = '0;
            fail_b_d    = '0;
            fail_code_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (chk_cnt_q != CNT_MAX) begin
                chk_cnt_d = chk_cnt_q + 1'b1;
            end
            if (beat_fail) begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                // Only the first failure of a run is kept.
                if (!fail_flag_q) begin
                    fail_flag_d = 1'b1;
                    fail_a_d    = a;
                    fail_b_d    = b;
                    fail_code_d = dut_flags;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            fail_flag_q <= 1'b0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_code_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            err_cnt_q   <= err_cnt_d;
            fail_flag_q <= fail_flag_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_code_q <= fail_code_d;
        end
    end

    // Registered outputs.
    always_comb begin
        chk_cnt   = chk_cnt_q;
        err_cnt   = err_cnt_q;
        fail_flag = fail_flag_q;
        fail_a    = fail_a_q;
        fail_b    = fail_b_q;
        fail_code = fail_code_q;
    end

endmodule

// File: tb/tb_cmp_checker.sv
// tb_cmp_checker: directed bench for cmp_checker. Two instances share one
// stimulus stream: u0 is unsigned with 16-bit counters, u1 is signed with
// 4-bit counters so saturation is reached within a single run.
module tb_cmp_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a        = '0;
    logic [3:0] b        = '0;
    logic       equal    = 1'b0;
    logic       greater  = 1'b0;
    logic       lower    = 1'b0;

    logic        u0_in_ready, u0_busy, u0_done, u0_fail_flag;
    logic [15:0] u0_chk_cnt, u0_err_cnt;
    logic [3:0]  u0_fail_a, u0_fail_b;
    logic [2:0]  u0_fail_code;

    logic        u1_in_ready, u1_busy, u1_done, u1_fail_flag;
    logic [3:0]  u1_chk_cnt, u1_err_cnt;
    logic [3:0]  u1_fail_a, u1_fail_b;
    logic [2:0]  u1_fail_code;

    cmp_checker u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .equal(equal), .greater(greater), .lower(lower),
        .in_ready(u0_in_ready), .busy(u0_busy), .done(u0_done),
        .chk_cnt(u0_chk_cnt), .err_cnt(u0_err_cnt), .fail_flag(u0_fail_flag),
        .fail_a(u0_fail_a), .fail_b(u0_fail_b), .fail_code(u0_fail_code)
    );

    cmp_checker #(.SIGNED(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .equal(equal), .greater(greater), .lower(lower),
        .in_ready(u1_in_ready), .busy(u1_busy), .done(u1_done),
        .chk_cnt(u1_chk_cnt), .err_cnt(u1_err_cnt), .fail_flag(u1_fail_flag),
        .fail_a(u1_fail_a), .fail_b(u1_fail_b), .fail_code(u1_fail_code)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models u0, index 1 models u1.
    bit m_ok = 0;
    bit m_running [2];
    bit m_finished[2];
    int m_beats[2];
    int m_chk[2];
    int m_err[2];
    bit m_fflag[2];
    int m_fa[2];
    int m_fb[2];
    int m_fc[2];
    int m_max[2] = '{65535, 15};

    function automatic logic [2:0] ref_flags(input int inst, input logic [3:0] av, input logic [3:0] bv);
        int ia = int'(av);
        int ib = int'(bv);
        if (inst == 1) begin
            if (ia >= 8) ia -= 16;
            if (ib >= 8) ib -= 16;
        end
        return {ia == ib, ia > ib, ia < ib};
    endfunction

    function automatic logic [2:0] uflags(input logic [3:0] av, input logic [3:0] bv);
        return {av == bv, av > bv, av < bv};
    endfunction

    // Model advance on every clock edge from the sampled inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_running[i] = 0; m_finished[i] = 0; m_beats[i] = 0;
                m_chk[i] = 0; m_err[i] = 0; m_fflag[i] = 0;
                m_fa[i] = 0; m_fb[i] = 0; m_fc[i] = 0;
            end else if (!m_running[i] && start) begin
                m_running[i] = 1; m_finished[i] = 0; m_beats[i] = 0;
                m_chk[i] = 0; m_err[i] = 0; m_fflag[i] = 0;
                m_fa[i] = 0; m_fb[i] = 0; m_fc[i] = 0;
            end else if (m_running[i] && in_valid) begin
                m_beats[i]++;
                if (m_chk[i] < m_max[i]) m_chk[i]++;
                if ({equal, greater, lower} != ref_flags(i, a, b)) begin
                    if (m_err[i] < m_max[i]) m_err[i]++;
                    if (!m_fflag[i]) begin
                        m_fflag[i] = 1;
                        m_fa[i] = int'(a);
                        m_fb[i] = int'(b);
                        m_fc[i] = int'({equal, greater, lower});
                    end
                end
                if (m_beats[i] == 256) begin
                    m_running[i]  = 0;
                    m_finished[i] = 1;
                end
            end
        end
        if (rst) m_ok = 1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            check("u0_in_ready", 32'(u0_in_ready), 32'(m_running[0]));
            check("u0_busy", 32'(u0_busy), 32'(m_running[0]));
            check("u0_done", 32'(u0_done), 32'(m_finished[0]));
            check("u0_chk_cnt", 32'(u0_chk_cnt), m_chk[0]);
            check("u0_err_cnt", 32'(u0_err_cnt), m_err[0]);
            check("u0_fail_flag", 32'(u0_fail_flag), 32'(m_fflag[0]));
            check("u0_fail_a", 32'(u0_fail_a), m_fa[0]);
            check("u0_fail_b", 32'(u0_fail_b), m_fb[0]);
            check("u0_fail_code", 32'(u0_fail_code), m_fc[0]);
            check("u1_in_ready", 32'(u1_in_ready), 32'(m_running[1]));
            check("u1_busy", 32'(u1_busy), 32'(m_running[1]));
            check("u1_done", 32'(u1_done), 32'(m_finished[1]));
            check("u1_chk_cnt", 32'(u1_chk_cnt), m_chk[1]);
            check("u1_err_cnt", 32'(u1_err_cnt), m_err[1]);
            check("u1_fail_flag", 32'(u1_fail_flag), 32'(m_fflag[1]));
            check("u1_fail_a", 32'(u1_fail_a), m_fa[1]);
            check("u1_fail_b", 32'(u1_fail_b), m_fb[1]);
            check("u1_fail_code", 32'(u1_fail_code), m_fc[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] f);
        in_valid = 1'b1;
        a = av;
        b = bv;
        {equal, greater, lower} = f;
        tick();
        in_valid = 1'b0;
    endtask

    // Full sweep k -> (a=k/16, b=k%16) with correct unsigned flags, except
    // the listed beat indices which carry the given override flags.
    task automatic sweep(input int n, input int bad0, input logic [2:0] f0,
                         input int bad1, input logic [2:0] f1, input bit gaps);
        logic [3:0] av, bv;
        for (int k = 0; k < n; k++) begin
            av = 4'(k / 16);
            bv = 4'(k % 16);
            if (k == bad0)      beat(av, bv, f0);
            else if (k == bad1) beat(av, bv, f1);
            else                beat(av, bv, uflags(av, bv));
            if (gaps) begin
                if (k == 254) check("gap_done_before_last", 32'(u0_done), 32'd0);
                if (k == 255) check("gap_done_on_last", 32'(u0_done), 32'd1);
                tick();
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        check("rst_busy", 32'(u0_busy), 32'd0);
        check("rst_done", 32'(u0_done), 32'd0);
        check("rst_chk", 32'(u0_chk_cnt), 32'd0);
        check("rst_flag", 32'(u0_fail_flag), 32'd0);

        // Full sweep with a correct unsigned comparator.
        pulse_start();
        check("start_busy", 32'(u0_busy), 32'd1);
        sweep(256, -1, 3'b000, -1, 3'b000, 1'b0);
        check("sweep_done", 32'(u0_done), 32'd1);
        check("sweep_chk", 32'(u0_chk_cnt), 32'd256);
        check("sweep_err", 32'(u0_err_cnt), 32'd0);
        check("sweep_flag", 32'(u0_fail_flag), 32'd0);
        // Signed instance: saturated counters, first failure at a=0,b=8.
        check("sat_chk", 32'(u1_chk_cnt), 32'd15);
        check("sat_err", 32'(u1_err_cnt), 32'd15);
        check("u1_first_a", 32'(u1_fail_a), 32'd0);
        check("u1_first_b", 32'(u1_fail_b), 32'd8);
        check("u1_first_code", 32'(u1_fail_code), 32'b001);

        // start in DONE clears; a=F,b=1 flagged "lower".
        pulse_start();
        check("restart_chk_clr", 32'(u0_chk_cnt), 32'd0);
        check("restart_done_clr", 32'(u0_done), 32'd0);
        beat(4'hF, 4'h1, 3'b001);
        check("signed_err", 32'(u1_err_cnt), 32'd0);
        check("unsigned_err", 32'(u0_err_cnt), 32'd1);
        check("unsigned_code", 32'(u0_fail_code), 32'b001);
        check("unsigned_fa", 32'(u0_fail_a), 32'hF);
        check("unsigned_fb", 32'(u0_fail_b), 32'h1);

        // start inside RUN is ignored.
        pulse_start();
        check("run_start_chk", 32'(u0_chk_cnt), 32'd1);
        check("run_start_err", 32'(u0_err_cnt), 32'd1);

        // Fresh run with two injected faults; only the first is captured.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_start();
        sweep(256, 10, 3'b110, 20, 3'b000, 1'b0);
        check("inj_err", 32'(u0_err_cnt), 32'd2);
        check("inj_fa", 32'(u0_fail_a), 32'd0);
        check("inj_fb", 32'(u0_fail_b), 32'd10);
        check("inj_code", 32'(u0_fail_code), 32'b110);
        check("inj_chk", 32'(u0_chk_cnt), 32'd256);

        // in_valid toggling every other cycle.
        pulse_start();
        sweep(256, -1, 3'b000, -1, 3'b000, 1'b1);
        check("gap_chk", 32'(u0_chk_cnt), 32'd256);
        check("gap_err", 32'(u0_err_cnt), 32'd0);
        // Beats outside RUN are ignored.
        beat(4'h3, 4'h3, 3'b000);
        check("idle_beat_err", 32'(u0_err_cnt), 32'd0);
        check("idle_beat_chk", 32'(u0_chk_cnt), 32'd256);

        // Reset mid-run, with start and in_valid also high.
        pulse_start();
        sweep(100, -1, 3'b000, -1, 3'b000, 1'b0);
        check("mid_chk", 32'(u0_chk_cnt), 32'd100);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("abort_busy", 32'(u0_busy), 32'd0);
        check("abort_ready", 32'(u0_in_ready), 32'd0);
        check("abort_done", 32'(u0_done), 32'd0);
        check("abort_chk", 32'(u0_chk_cnt), 32'd0);
        check("abort_err", 32'(u0_err_cnt), 32'd0);
        check("abort_code", 32'(u0_fail_code), 32'd0);

        // New run whose final beat fails: counted and captured on entry to DONE.
        pulse_start();
        sweep(256, 255, 3'b010, -1, 3'b000, 1'b0);
        check("last_done", 32'(u0_done), 32'd1);
        check("last_chk", 32'(u0_chk_cnt), 32'd256);
        check("last_err", 32'(u0_err_cnt), 32'd1);
        check("last_fa", 32'(u0_fail_a), 32'hF);
        check("last_fb", 32'(u0_fail_b), 32'hF);
        check("last_code", 32'(u0_fail_code), 32'b010);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
